// File: rtl/audio_sample_fifo_if.sv
// Handshake bundle between the opcode decoder / I2S sender and audio_sample_fifo.
// The master side drives samples, control pulses and pops; the slave side is the FIFO.
interface audio_sample_fifo_if #(
    parameter int AW = 4
);
    logic          in_valid;
    logic [31:0]   in_data;
    logic          audio_starts;
    logic          end_audio_sample;
    logic          audio_22khz;
    logic          pop;
    logic [31:0]   out_data;
    logic          out_valid;
    logic [AW:0]   level;
    logic          request_mode;
    logic          request_tick;
    logic          overflow;
    logic          underflow;

    modport master (
        output in_valid, in_data, audio_starts, end_audio_sample, audio_22khz, pop,
        input  out_data, out_valid, level, request_mode, request_tick, overflow, underflow
    );

    modport slave (
        input  in_valid, in_data, audio_starts, end_audio_sample, audio_22khz, pop,
        output out_data, out_valid, level, request_mode, request_tick, overflow, underflow
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Audio sample FIFO between packet decode and the I2S serializer, with host request pacing.
// Optional 22 kHz word duplication is built when AUDIO_FIFO_DUP22_EN is defined.
module audio_sample_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int LOW_WATER = 8,
    parameter int HOLDOFF   = 2000
) (
    input  logic                 mon_clk,
    input  logic                 reset,
    audio_sample_fifo_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_LOW   = (AW+1)'(LOW_WATER);
    localparam logic [11:0] HOLD_LOAD = 12'(HOLDOFF - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [11:0]     r_hold_cnt;
    logic            r_tick;
    logic            w_out_valid;
    logic            w_request_mode;
    logic            w_pop_acc;
    logic            w_rd_adv;
    logic            w_push;
    logic            w_tick_cond;

    always_ff @(posedge mon_clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // A start pulse always beats a simultaneous end pulse, even where the start itself is ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.audio_starts) w_next_state = PRIME;
            PRIME: begin
                if (bus.end_audio_sample && !bus.audio_starts) w_next_state = DRAIN;
                else if (r_level >= LVL_LOW)                   w_next_state = STREAM;
            end
            STREAM:  if (bus.end_audio_sample && !bus.audio_starts) w_next_state = DRAIN;
            DRAIN: begin
                if (bus.audio_starts)       w_next_state = PRIME;
                else if (r_level == '0)     w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_request_mode = (r_state == PRIME) || (r_state == STREAM);
        w_out_valid    = (r_level != '0) && ((r_state == STREAM) || (r_state == DRAIN));
    end

    assign w_pop_acc = bus.pop & w_out_valid;

`ifdef AUDIO_FIFO_DUP22_EN
    logic r_dup;
    logic r_phase;
    logic w_start_acc;

    // Only a start that actually enters PRIME resamples the rate and realigns the pair phase.
    assign w_start_acc = bus.audio_starts && ((r_state == IDLE) || (r_state == DRAIN));

    always_ff @(posedge mon_clk or posedge reset) begin
        if (reset) begin
            r_dup   <= 1'b0;
            r_phase <= 1'b0;
        end else if (w_start_acc) begin
            r_dup   <= bus.audio_22khz;
            r_phase <= 1'b0;
        end else if (w_pop_acc && r_dup) begin
            r_phase <= ~r_phase;
        end
    end

    assign w_rd_adv = w_pop_acc & (~r_dup | r_phase);
`else
    logic w_unused_22khz;
    assign w_unused_22khz = bus.audio_22khz;
    assign w_rd_adv       = w_pop_acc;
`endif

    // A word that leaves the FIFO this cycle frees a slot for a same-cycle push.
    assign w_push      = bus.in_valid & ((r_level != LVL_FULL) | w_rd_adv);
    assign w_tick_cond = w_request_mode & (r_level <= LVL_LOW) & (r_hold_cnt == '0);

    always_ff @(posedge mon_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_hold_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_rd_adv};
            r_tick  <= w_tick_cond;
            // Held at zero outside request mode, so the first tick after entering PRIME is immediate.
            if (!w_request_mode)       r_hold_cnt <= '0;
            else if (w_tick_cond)      r_hold_cnt <= HOLD_LOAD;
            else if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge mon_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
    end

    assign bus.out_data     = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.out_valid    = w_out_valid;
    assign bus.level        = r_level;
    assign bus.request_mode = w_request_mode;
    assign bus.request_tick = r_tick;
    assign bus.overflow     = bus.in_valid & ~w_push;
    assign bus.underflow    = bus.pop & ~w_out_valid;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_audio_sample_fifo;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int LW      = 8;
    localparam int HOLDOFF = 2000;

    logic mon_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 mon_clk = ~mon_clk;

    audio_sample_fifo_if #(.AW(AW)) bus ();

    audio_sample_fifo #(
        .DEPTH(DEPTH), .AW(AW), .LOW_WATER(LW), .HOLDOFF(HOLDOFF)
    ) dut (
        .mon_clk (mon_clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        bit          iv;
        logic [31:0] id;
        bit          as;
        bit          ea;
        bit          pp;
        int          lvl;
        bit          ov;
        logic [31:0] od;
        bit          mode;
        bit          tick;
        bit          ovf;
        bit          und;
    } vec_t;

    vec_t tbl [12];

    // Reference model: word queue, phase names 0 idle / 1 prime / 2 stream / 3 drain,
    // and the earliest cycle at which another request tick may be raised.
    logic [31:0] mq [$];
    int          mst;
    bit          mdup, mphase, mtick;
    longint      cyc, allow_at;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] obs_od;
    int          obs_lvl;
    bit          obs_ov, obs_mode, obs_tick, obs_ovf, obs_und;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst = 0; mdup = 0; mphase = 0; mtick = 0; allow_at = 0;
    endtask

    task automatic do_reset();
        bus.in_valid = 0; bus.in_data = '0; bus.audio_starts = 0;
        bus.end_audio_sample = 0; bus.audio_22khz = 0; bus.pop = 0;
        reset = 1'b1;
        @(negedge mon_clk);
        chk("rst_level",     32'(bus.level),    0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  bus.out_data,      0);
        chk("rst_req_mode",  32'(bus.request_mode), 0);
        chk("rst_req_tick",  32'(bus.request_tick), 0);
        chk("rst_overflow",  32'(bus.overflow),  0);
        chk("rst_underflow", 32'(bus.underflow), 0);
        model_reset();
        @(posedge mon_clk); #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic cycle(input bit iv, input logic [31:0] id, input bit as, input bit ea,
                         input bit k22, input bit pp);
        int sz, nst;
        bit ovv, mode_e, pop_ok, consume, ovf_e, und_e, start_ok;
        logic [31:0] od_e;
        bus.in_valid = iv; bus.in_data = id; bus.audio_starts = as;
        bus.end_audio_sample = ea; bus.audio_22khz = k22; bus.pop = pp;
        @(negedge mon_clk);
        obs_od = bus.out_data; obs_lvl = int'(bus.level); obs_ov = bus.out_valid;
        obs_mode = bus.request_mode; obs_tick = bus.request_tick;
        obs_ovf = bus.overflow; obs_und = bus.underflow;

        sz      = mq.size();
        ovv     = (sz != 0) && (mst == 2 || mst == 3);
        od_e    = ovv ? mq[0] : 32'h0;
        mode_e  = (mst == 1 || mst == 2);
        pop_ok  = pp && ovv;
        consume = pop_ok && (!mdup || mphase);
        ovf_e   = iv && (sz == DEPTH) && !consume;
        und_e   = pp && !ovv;
        chk("level",        32'(obs_lvl),  32'(sz));
        chk("out_valid",    32'(obs_ov),   32'(ovv));
        chk("out_data",     obs_od,        od_e);
        chk("request_mode", 32'(obs_mode), 32'(mode_e));
        chk("request_tick", 32'(obs_tick), 32'(mtick));
        chk("overflow",     32'(obs_ovf),  32'(ovf_e));
        chk("underflow",    32'(obs_und),  32'(und_e));

        mtick = mode_e && (sz <= LW) && (cyc >= allow_at);
        if (mtick) allow_at = cyc + HOLDOFF;
        if (pop_ok && mdup) mphase = !mphase;
        if (consume) void'(mq.pop_front());
        if (iv && !ovf_e) mq.push_back(id);
        nst = mst;
        case (mst)
            0: if (as) nst = 1;
            1: if (ea && !as) nst = 3; else if (sz >= LW) nst = 2;
            2: if (ea && !as) nst = 3;
            default: if (as) nst = 1; else if (sz == 0) nst = 0;
        endcase
        start_ok = as && (mst == 0 || mst == 3);
        if (start_ok) begin
            mphase = 0;
`ifdef AUDIO_FIFO_DUP22_EN
            mdup = k22;
`endif
        end
        if (nst == 1 && mst != 1) allow_at = cyc + 1;
        mst = nst;
        cyc++;
        @(posedge mon_clk); #1;
    endtask

    logic [31:0] got [4];
    logic [31:0] want [4];

    initial begin
        cyc = 0;
        model_reset();
        #1;
        do_reset();

        for (int i = 0; i < 12; i++) tbl[i] = '{default: 0};
        tbl[0].as = 1;
        for (int i = 1; i < 12; i++) tbl[i].mode = 1;
        tbl[2].tick = 1;
        for (int k = 1; k <= 8; k++) begin
            tbl[k+1].iv  = 1;
            tbl[k+1].id  = {16'(k), 16'(k)};
            tbl[k+2].lvl = k;
        end
        tbl[11].lvl = 8;
        tbl[11].ov  = 1;
        tbl[11].od  = 32'h0001_0001;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, tbl[i].id, tbl[i].as, tbl[i].ea, 1'b0, tbl[i].pp);
            chk($sformatf("tbl%0d_level", i),     32'(obs_lvl),  32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_out_valid", i), 32'(obs_ov),   32'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_data", i),  obs_od,        tbl[i].od);
            chk($sformatf("tbl%0d_mode", i),      32'(obs_mode), 32'(tbl[i].mode));
            chk($sformatf("tbl%0d_tick", i),      32'(obs_tick), 32'(tbl[i].tick));
            chk($sformatf("tbl%0d_ovf", i),       32'(obs_ovf),  32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_und", i),       32'(obs_und),  32'(tbl[i].und));
        end

        // Fill to full, then one word too many.
        for (int k = 9; k <= 16; k++) cycle(1, {16'(k), 16'(k)}, 0, 0, 0, 0);
        cycle(1, 32'hDEAD_0017, 0, 0, 0, 0);
        chk("ovf_on_17th", 32'(obs_ovf), 1);
        chk("lvl_full", 32'(obs_lvl), 16);
        cycle(1, 32'h0011_0011, 0, 0, 0, 1);
        chk("no_ovf_pushpop", 32'(obs_ovf), 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("lvl_after_pushpop", 32'(obs_lvl), 16);
        chk("head_advanced", obs_od, 32'h0002_0002);

        // Drain down to three words, end audio, pop them out, then one pop too many.
        for (int k = 0; k < 13; k++) cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0);
        chk("lvl3_at_end", 32'(obs_lvl), 3);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0, 1);
            chk($sformatf("drain_mode_off%0d", k), 32'(obs_mode), 0);
        end
        cycle(0, 0, 0, 0, 0, 1);
        chk("underflow_4th", 32'(obs_und), 1);
        chk("lvl0_after_drain", 32'(obs_lvl), 0);

        // Reset with words resident (pushes accepted while idle).
        for (int k = 0; k < 5; k++) cycle(1, 32'h5000_0000 + k, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("idle_lvl5", 32'(obs_lvl), 5);
        do_reset();

        // Two words served in drain, with the 22 kHz flag raised at start.
        cycle(0, 0, 1, 0, 1, 0);
        cycle(1, 32'hAAAA_0001, 0, 0, 0, 0);
        cycle(1, 32'hBBBB_0002, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 1);
            got[k] = obs_od;
        end
`ifdef AUDIO_FIFO_DUP22_EN
        want[0] = 32'hAAAA_0001; want[1] = 32'hAAAA_0001;
        want[2] = 32'hBBBB_0002; want[3] = 32'hBBBB_0002;
`else
        want[0] = 32'hAAAA_0001; want[1] = 32'hBBBB_0002;
        want[2] = 32'h0;         want[3] = 32'h0;
`endif
        for (int k = 0; k < 4; k++) chk($sformatf("dup_pop%0d", k), got[k], want[k]);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cycle(($urandom % 3) == 0, $urandom, ($urandom % 64) == 0, ($urandom % 64) == 0,
                  1'($urandom % 2), ($urandom % 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
